register_bus_reader: RTL and testbench

Read-side controller for the shared register bus. Source registers drive this bus through active-low chip selects: cs=1 means the source is high-Z, cs=0 means it drives its Q. The block takes a read request by source index, drives exactly one cs low, waits a settle interval, captures the bus and returns the data on a valid/ready response port. It sits between the datapath sequencer and the bank of bus-attached registers (PC, EX and similar).

---
 rtl/register_bus_reader.sv | 127 ++++++++++++
 tb/tb_register_bus_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bus_reader.sv
// Read-side controller for the shared register bus: drives one active-low chip
// select, waits a Tick-qualified settle interval, captures the bus and returns it.
module register_bus_reader #(
  parameter int NrOfBits     = 32,
  parameter int NrOfSources  = 4,
  parameter int AddrBits     = 2,
  parameter int SettleCycles = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  input  logic                   ReqValid,
  input  logic [AddrBits-1:0]    ReqAddr,
  output logic                   ReqReady,
  input  logic [NrOfBits-1:0]    BusD,
  output logic [NrOfSources-1:0] cs,
  output logic                   RspValid,
  output logic [NrOfBits-1:0]    RspData,
  output logic                   RspErr,
  input  logic                   RspReady
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [NrOfSources-1:0] AllOnes    = '1;
  localparam logic [NrOfSources-1:0] OneLsb     = NrOfSources'(1);
  localparam logic [3:0]             SettleLoad = 4'(SettleCycles - 1);
  localparam logic [31:0]            NrSrcWide  = 32'(NrOfSources);

  state_e                  state_q, state_d;
  logic [NrOfSources-1:0]  cs_q, cs_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [NrOfBits-1:0]     rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    addr_ok;

  // Unsigned compare; zero-extending both sides keeps any AddrBits legal.
  assign addr_ok = (32'(ReqAddr) < NrSrcWide);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    cs_d        = cs_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (ReqValid && Tick) begin
          if (addr_ok) begin
            // The decoded select register doubles as the latched address.
            cnt_d   = SettleLoad;
            cs_d    = ~(OneLsb << ReqAddr);
            state_d = DRIVE;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      DRIVE: begin
        if (Tick) begin
          if (cnt_q == 4'd0) begin
            rsp_data_d  = BusD;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            cs_d        = AllOnes;
            state_d     = RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      RESP: begin
        // The response handshake is deliberately not Tick-gated.
        if (rsp_valid_q && RspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = AllOnes;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Reset) begin
      state_q     <= IDLE;
      cs_q        <= AllOnes;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign ReqReady = ready_q;
  assign cs       = cs_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspErr   = rsp_err_q;

endmodule

// File: tb/tb_register_bus_reader.sv
// Self-checking bench: two reader instances (4 sources/S=1 and 3 sources/S=3) on
// modelled buses, with a transaction-level reference and a bus-safety monitor.
module tb_register_bus_reader;

  localparam int W = 32;
  localparam logic [W-1:0] FLOAT = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         tick;
  logic         req_valid [2];
  logic [1:0]   req_addr  [2];
  logic         req_ready [2];
  logic         rsp_valid [2];
  logic [W-1:0] rsp_data  [2];
  logic         rsp_err   [2];
  logic         rsp_ready [2];
  logic [W-1:0] bus_d     [2];
  logic [3:0]   cs_a;
  logic [2:0]   cs_b;
  logic [3:0]   cs_w      [2];
  logic [W-1:0] src       [2][4];

  int n_src  [2] = '{4, 3};
  int settle [2] = '{1, 3};

  int checks = 0;
  int errors = 0;

  assign cs_w[0] = cs_a;
  assign cs_w[1] = {1'b1, cs_b};

  // Resolved bus: wired-OR of every selected source, a float pattern when none drive.
  always_comb begin : resolve
    logic [W-1:0] acc;
    for (int d = 0; d < 2; d++) begin
      acc = '0;
      for (int i = 0; i < 4; i++) if (!cs_w[d][i]) acc = acc | src[d][i];
      bus_d[d] = (cs_w[d] == 4'hF) ? FLOAT : acc;
    end
  end

  register_bus_reader #(.NrOfBits(W), .NrOfSources(4), .AddrBits(2), .SettleCycles(1)) u_dut_a (
    .Clock(clk), .Reset(reset), .Tick(tick), .ReqValid(req_valid[0]), .ReqAddr(req_addr[0]),
    .ReqReady(req_ready[0]), .BusD(bus_d[0]), .cs(cs_a), .RspValid(rsp_valid[0]),
    .RspData(rsp_data[0]), .RspErr(rsp_err[0]), .RspReady(rsp_ready[0])
  );

  register_bus_reader #(.NrOfBits(W), .NrOfSources(3), .AddrBits(2), .SettleCycles(3)) u_dut_b (
    .Clock(clk), .Reset(reset), .Tick(tick), .ReqValid(req_valid[1]), .ReqAddr(req_addr[1]),
    .ReqReady(req_ready[1]), .BusD(bus_d[1]), .cs(cs_b), .RspValid(rsp_valid[1]),
    .RspData(rsp_data[1]), .RspErr(rsp_err[1]), .RspReady(rsp_ready[1])
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic tick_val(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Bus-safety monitor: one-hot-zero, no cs change on Tick=0 edges, turnaround >= 2.
  logic       mon_on = 1'b0;
  logic       tick_e, rst_e;
  logic [3:0] cs_prev [2];
  int         gap     [2];
  logic       in_win  [2];
  logic       had_win [2];

  always @(posedge clk) begin
    tick_e <= tick;
    rst_e  <= reset;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mon_on) begin
        check($sformatf("cs_onehot[%0d]", d),
              W'((cs_w[d] == 4'hF) || ($countones(~cs_w[d]) == 1)), 1);
        if (!rst_e && !tick_e) check($sformatf("cs_hold_notick[%0d]", d), cs_w[d], cs_prev[d]);
        if (rst_e) begin
          had_win[d] <= 1'b0;
          in_win[d]  <= 1'b0;
          gap[d]     <= 0;
        end else if (cs_w[d] == 4'hF) begin
          gap[d]    <= gap[d] + 1;
          in_win[d] <= 1'b0;
        end else if (!in_win[d]) begin
          if (had_win[d]) check($sformatf("turnaround[%0d]", d), W'(gap[d] >= 2), 1);
          had_win[d] <= 1'b1;
          in_win[d]  <= 1'b1;
          gap[d]     <= 0;
        end
      end else begin
        had_win[d] <= 1'b0;
        in_win[d]  <= 1'b0;
        gap[d]     <= 0;
      end
      cs_prev[d] <= cs_w[d];
    end
  end

  // One full read transaction on instance d; called and returns at a negedge.
  task automatic do_read(input int d, input logic [1:0] addr, input int mode,
                         input int hold, input bit rnd);
    logic [W-1:0] exp_data;
    logic [3:0]   exp_cs;
    bit           err, accepted;
    logic         pre_ready;
    int           cyc, ticks, guard;

    if (rnd) for (int i = 0; i < 4; i++) src[d][i] = $urandom;
    err      = (int'(addr) >= n_src[d]);
    exp_data = err ? '0 : src[d][addr];
    exp_cs   = err ? 4'hF : ~(4'b0001 << addr);

    check($sformatf("ready_idle[%0d]", d), req_ready[d], 1);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    rsp_ready[d] = 1'b0;
    accepted     = 1'b0;
    cyc          = 0;
    while (!accepted && cyc < 50) begin
      tick      = tick_val(mode, cyc);
      pre_ready = req_ready[d];
      @(negedge clk);
      cyc++;
      if (pre_ready && tick) accepted = 1'b1;
    end
    check($sformatf("accept[%0d]", d), W'(accepted), 1);
    req_valid[d] = 1'b0;

    if (!err) begin
      ticks = 0;
      guard = 0;
      while (ticks < settle[d] && guard < 100) begin
        check($sformatf("cs_drive[%0d]", d), cs_w[d], exp_cs);
        check($sformatf("rsp_valid_drive[%0d]", d), rsp_valid[d], 0);
        tick = tick_val(mode, cyc);
        @(negedge clk);
        cyc++;
        guard++;
        if (tick) ticks++;
      end
      check($sformatf("settle_ticks[%0d]", d), W'(ticks), W'(settle[d]));
    end

    check($sformatf("rsp_valid[%0d]", d), rsp_valid[d], 1);
    check($sformatf("rsp_data[%0d]", d), rsp_data[d], exp_data);
    check($sformatf("rsp_err[%0d]", d), rsp_err[d], W'(err));
    check($sformatf("cs_released[%0d]", d), cs_w[d], 4'hF);

    // Backpressure with a stray request that must be ignored.
    req_valid[d] = 1'b1;
    req_addr[d]  = 2'($urandom_range(0, 3));
    for (int h = 0; h < hold; h++) begin
      tick = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("bp_valid[%0d]", d), rsp_valid[d], 1);
      check($sformatf("bp_data[%0d]", d), rsp_data[d], exp_data);
      check($sformatf("bp_err[%0d]", d), rsp_err[d], W'(err));
      check($sformatf("bp_ready[%0d]", d), req_ready[d], 0);
      check($sformatf("bp_cs[%0d]", d), cs_w[d], 4'hF);
    end

    rsp_ready[d] = 1'b1;
    tick         = 1'($urandom_range(0, 1));
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    check($sformatf("hs_valid[%0d]", d), rsp_valid[d], 0);
    check($sformatf("hs_data_kept[%0d]", d), rsp_data[d], exp_data);
    check($sformatf("hs_ready[%0d]", d), req_ready[d], 1);
    check($sformatf("hs_cs[%0d]", d), cs_w[d], 4'hF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_addr[d]  = 2'd0;
      rsp_ready[d] = 1'b0;
      for (int i = 0; i < 4; i++) src[d][i] = $urandom;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_cs[%0d]", d), cs_w[d], 4'hF);
      check($sformatf("rst_valid[%0d]", d), rsp_valid[d], 0);
      check($sformatf("rst_data[%0d]", d), rsp_data[d], 0);
      check($sformatf("rst_err[%0d]", d), rsp_err[d], 0);
      check($sformatf("rst_ready[%0d]", d), req_ready[d], 1);
    end
    reset  = 1'b0;
    mon_on = 1'b1;

    // Basic read, S=1.
    src[0][2] = 32'hDEAD_BEEF;
    do_read(0, 2'd2, 0, 0, 1'b0);
    // Settle with toggling Tick, S=3.
    do_read(1, 2'd1, 1, 0, 1'b1);
    // Error path on the 3-source instance.
    do_read(1, 2'd3, 0, 1, 1'b1);
    // Backpressure then back-to-back read.
    do_read(0, 2'd1, 0, 5, 1'b1);
    do_read(0, 2'd0, 0, 0, 1'b1);

    // Reset mid-DRIVE: Tick=0 holds the window open, then reset releases it.
    tick         = 1'b1;
    req_valid[0] = 1'b1;
    req_addr[0]  = 2'd0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("mid_cs_low", cs_w[0], 4'b1110);
    tick = 1'b0;
    @(negedge clk);
    check("mid_cs_frozen", cs_w[0], 4'b1110);
    check("mid_no_valid", rsp_valid[0], 0);
    reset = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_cs", cs_w[0], 4'hF);
    check("mid_rst_ready", req_ready[0], 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", rsp_valid[0], 0);
    end

    // Randomized traffic across both instances.
    for (int n = 0; n < 40; n++) begin
      do_read($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 2),
              $urandom_range(0, 3), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
